z80_io_slot_controller: RTL and testbench

Parametrised I/O slot decoder and per-slot programmable wait-state generator for the Z80 bus controller. It generalises the fixed 8-slot I/O decode and the single wait-state generator:
- slot count and maximum wait depth are parameters;
- every slot gets its own wait-count register, written over the Z80 I/O bus;
- wait insertion runs as a cycle-counted state machine.

It sits between the CPU control/address lines and the peripheral chip selects.

---
 rtl/z80_io_slot_controller_pkg.sv | 14 +
 rtl/z80_wait_counter.sv | 36 +++
 rtl/z80_io_slot_controller.sv | 148 ++++++++++++++
 tb/tb_z80_io_slot_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/z80_io_slot_controller_pkg.sv
// Shared types and helpers for the Z80 I/O slot decoder and wait-state generator.
package z80_io_slot_controller_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } wait_state_e;

  function automatic int unsigned slot_bits(input int unsigned slots);
    return $clog2(slots);
  endfunction

endpackage

// File: rtl/z80_wait_counter.sv
// Load/decrement counter for one wait burst; flags zero and last-wait (count == 1).
module z80_wait_counter #(
  parameter int unsigned WAIT_BITS = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [WAIT_BITS-1:0] i_load_val,
  input  logic                 i_dec,
  output logic                 o_zero,
  output logic                 o_last
);

  logic [WAIT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);
  assign o_last = (cnt_q == WAIT_BITS'(1));

endmodule

// File: rtl/z80_io_slot_controller.sv
// I/O slot decoder with per-slot programmable wait states for the Z80 bus.
// Define Z80_IOSLOT_READBACK_EN to make the wait-count registers readable.
module z80_io_slot_controller
  import z80_io_slot_controller_pkg::*;
#(
  parameter int unsigned SLOTS        = 8,
  parameter int unsigned WAIT_BITS    = 3,
  parameter int unsigned CFG_SLOT     = SLOTS - 2,
  parameter int unsigned DEFAULT_WAIT = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_m1_n,
  input  logic             i_iorq_n,
  input  logic             i_rd_n,
  input  logic             i_wr_n,
  input  logic [7:0]       i_addr,
  input  logic [7:0]       i_data,
  output logic [7:0]       o_data,
  output logic             o_data_en,
  output logic [SLOTS-1:0] o_cs_n,
  output logic             o_wait_n
);

  localparam int unsigned SlotBits = slot_bits(SLOTS);

  logic                 iorq;
  logic [SlotBits-1:0]  slot;
  logic [SlotBits-1:0]  reg_idx;
  logic                 cfg_sel;

  assign iorq    = ~i_iorq_n & i_m1_n;
  assign slot    = i_addr[7 -: SlotBits];
  assign reg_idx = i_addr[SlotBits-1:0];
  assign cfg_sel = (slot == SlotBits'(CFG_SLOT));

  always_comb begin
    o_cs_n = '1;
    if (iorq) begin
      o_cs_n[slot] = 1'b0;
    end
  end

  // Register file; wr_seen_q limits each bus cycle to a single write.
  logic [WAIT_BITS-1:0] wait_cnt_q [SLOTS];
  logic                 wr_seen_q;
  logic                 wr_act;
  logic                 wr_en;

  assign wr_act = iorq & cfg_sel & ~i_wr_n;
  assign wr_en  = wr_act & ~wr_seen_q & (reg_idx != SlotBits'(CFG_SLOT));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_seen_q <= 1'b0;
      for (int unsigned k = 0; k < SLOTS; k++) begin
        wait_cnt_q[k] <= (k == CFG_SLOT) ? '0 : WAIT_BITS'(DEFAULT_WAIT);
      end
    end else begin
      wr_seen_q <= wr_act;
      if (wr_en) begin
        wait_cnt_q[reg_idx] <= i_data[WAIT_BITS-1:0];
      end
    end
  end

  // Wait-state FSM; the single counter is loaded from the slot latched in StIdle.
  wait_state_e          state_q;
  logic                 wait_n_q;
  logic [WAIT_BITS-1:0] sel_cnt;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic                 cnt_last;

  assign sel_cnt  = wait_cnt_q[slot];
  assign cnt_load = (state_q == StIdle) & iorq & (sel_cnt != '0);
  assign cnt_dec  = (state_q == StWait) & iorq;

  z80_wait_counter #(
    .WAIT_BITS (WAIT_BITS)
  ) u_wait_counter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (cnt_load),
    .i_load_val (sel_cnt),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero),
    .o_last     (cnt_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      wait_n_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (iorq) begin
            if (sel_cnt == '0) begin
              state_q <= StDone;
            end else begin
              wait_n_q <= 1'b0;
              state_q  <= StWait;
            end
          end
        end
        StWait: begin
          if (!iorq) begin
            wait_n_q <= 1'b1;
            state_q  <= StIdle;
          end else if (cnt_last || cnt_zero) begin
            wait_n_q <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (!iorq) begin
            state_q <= StIdle;
          end
        end
        default: begin
          wait_n_q <= 1'b1;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign o_wait_n = wait_n_q;

`ifdef Z80_IOSLOT_READBACK_EN
  always_comb begin
    o_data_en = iorq & cfg_sel & ~i_rd_n;
    o_data    = '0;
    if (o_data_en && (reg_idx != SlotBits'(CFG_SLOT))) begin
      o_data = 8'(wait_cnt_q[reg_idx]);
    end
  end
`else
  assign o_data    = '0;
  assign o_data_en = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{i_rd_n, i_data, i_addr};

endmodule

// File: tb/tb_z80_io_slot_controller.sv
// Directed self-checking bench for z80_io_slot_controller (SLOTS=8, CFG_SLOT=6, WAIT_BITS=3).
module tb_z80_io_slot_controller;

  logic       i_clk;
  logic       i_reset;
  logic       i_m1_n;
  logic       i_iorq_n;
  logic       i_rd_n;
  logic       i_wr_n;
  logic [7:0] i_addr;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       o_data_en;
  logic [7:0] o_cs_n;
  logic       o_wait_n;

  int n_checks = 0;
  int n_fails  = 0;

  z80_io_slot_controller #(
    .SLOTS        (8),
    .WAIT_BITS    (3),
    .CFG_SLOT     (6),
    .DEFAULT_WAIT (2)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_m1_n    (i_m1_n),
    .i_iorq_n  (i_iorq_n),
    .i_rd_n    (i_rd_n),
    .i_wr_n    (i_wr_n),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .o_data    (o_data),
    .o_data_en (o_data_en),
    .o_cs_n    (o_cs_n),
    .o_wait_n  (o_wait_n)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bus_idle();
    i_iorq_n = 1'b1;
    i_rd_n   = 1'b1;
    i_wr_n   = 1'b1;
    i_m1_n   = 1'b1;
  endtask

  // Full I/O read cycle: checks chip selects, wait start and total wait length.
  task automatic io_cycle(input string tag, input logic [7:0] addr, input logic [7:0] exp_cs,
                          input int exp_waits);
    int low;
    i_addr   = addr;
    i_rd_n   = 1'b0;
    i_iorq_n = 1'b0;
    #1;
    check_eq({tag, "_cs"}, 32'(o_cs_n), 32'(exp_cs));
    check_eq({tag, "_pre"}, 32'(o_wait_n), 32'd1);
    tick();
    check_eq({tag, "_first"}, 32'(o_wait_n), (exp_waits == 0) ? 32'd1 : 32'd0);
    low = o_wait_n ? 0 : 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!o_wait_n) low++;
    end
    check_eq({tag, "_waits"}, 32'(low), 32'(exp_waits));
    bus_idle();
    tick();
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [7:0] data);
    i_addr   = addr;
    i_data   = data;
    i_iorq_n = 1'b0;
    i_wr_n   = 1'b0;
    tick();
    tick();
    bus_idle();
    tick();
  endtask

  initial begin
    bus_idle();
    i_addr  = 8'h00;
    i_data  = 8'h00;
    i_reset = 1'b1;
    tick();
    tick();
    check_eq("rst_wait_n", 32'(o_wait_n), 32'd1);
    check_eq("rst_data_en", 32'(o_data_en), 32'd0);
    check_eq("rst_data", 32'(o_data), 32'd0);
    check_eq("rst_cs", 32'(o_cs_n), 32'hFF);
    i_reset = 1'b0;
    tick();

    io_cycle("slot1", 8'h20, 8'hFD, 2);

    // Data changes while WR is still held; only the first edge may write.
    i_addr   = 8'hC3;
    i_data   = 8'h05;
    i_iorq_n = 1'b0;
    i_wr_n   = 1'b0;
    tick();
    i_data = 8'h01;
    tick();
    bus_idle();
    tick();
    io_cycle("slot3_w5", 8'h60, 8'hF7, 5);

    i_addr   = 8'hC3;
    i_rd_n   = 1'b0;
    i_iorq_n = 1'b0;
    #1;
`ifdef Z80_IOSLOT_READBACK_EN
    check_eq("rb_en", 32'(o_data_en), 32'd1);
    check_eq("rb_data", 32'(o_data), 32'h05);
`else
    check_eq("rb_en", 32'(o_data_en), 32'd0);
    check_eq("rb_data", 32'(o_data), 32'h00);
`endif
    tick();
    bus_idle();
    tick();

    wr_reg(8'hC3, 8'hFF);
    io_cycle("slot3_w7", 8'h60, 8'hF7, 7);

    wr_reg(8'hC2, 8'h00);
    io_cycle("slot2_w0", 8'h40, 8'hFB, 0);

    wr_reg(8'hC6, 8'h03);
    io_cycle("cfg_slot", 8'hC0, 8'hBF, 0);

    // Interrupt acknowledge: no chip select, no waits.
    i_addr   = 8'h00;
    i_m1_n   = 1'b0;
    i_iorq_n = 1'b0;
    #1;
    check_eq("inta_cs", 32'(o_cs_n), 32'hFF);
    begin
      int low_inta = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (!o_wait_n) low_inta++;
      end
      check_eq("inta_waits", 32'(low_inta), 32'd0);
    end
    bus_idle();
    tick();

    // IORQ dropped mid-burst releases WAIT on the next edge.
    i_addr   = 8'h60;
    i_rd_n   = 1'b0;
    i_iorq_n = 1'b0;
    tick();
    check_eq("abort_low", 32'(o_wait_n), 32'd0);
    tick();
    bus_idle();
    tick();
    check_eq("abort_high", 32'(o_wait_n), 32'd1);
    tick();
    io_cycle("after_abort", 8'h60, 8'hF7, 7);

    // Reset on the second wait clock of a 7-wait burst.
    i_addr   = 8'h60;
    i_rd_n   = 1'b0;
    i_iorq_n = 1'b0;
    tick();
    check_eq("rstb_low", 32'(o_wait_n), 32'd0);
    tick();
    i_reset = 1'b1;
    tick();
    check_eq("rstb_high", 32'(o_wait_n), 32'd1);
    i_reset = 1'b0;
    bus_idle();
    tick();
    io_cycle("post_rst3", 8'h60, 8'hF7, 2);
    io_cycle("post_rst2", 8'h40, 8'hFB, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
